// File: rtl/dms_pfd_lockdet.sv
// Digital PFD for the CDR loop: synchronised ref/fb edge compare,
// charge-pump up/down, signed phase error, cycle-slip flag and lock detect.
module dms_pfd_lockdet #(
    parameter int SYNC_STAGES = 2,
    parameter int ERR_W       = 8,
    parameter int RST_DLY     = 2,
    parameter int LOCK_TOL    = 2,
    parameter int LOCK_CNT    = 16,
    parameter int UNLOCK_CNT  = 4
) (
    input  logic                    ck,
    input  logic                    rst_n,
    input  logic                    refclk,
    input  logic                    fbclk,
    output logic                    up,
    output logic                    down,
    output logic signed [ERR_W-1:0] phase_err,
    output logic                    err_valid,
    output logic                    slip,
    output logic                    locked
);

    localparam int CW = ERR_W - 1;
    localparam int DW = (RST_DLY > 1) ? $clog2(RST_DLY) : 1;
    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam int BW = $clog2(UNLOCK_CNT + 1);
    localparam logic [CW-1:0] CMAX = '1;

    typedef enum logic [1:0] {S_IDLE, S_UP, S_DN, S_RESET} state_e;

    logic [SYNC_STAGES-1:0] ref_sync_q, fb_sync_q;
    logic                   ref_prev_q, fb_prev_q;
    logic                   ref_rise, fb_rise;
    logic                   ref_ev, fb_ev;

    state_e                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d, cnt_inc;
    logic [DW-1:0]          dly_q, dly_d;
    logic                   ref_pend_q, ref_pend_d;
    logic                   fb_pend_q, fb_pend_d;
    logic                   load;
    logic signed [ERR_W-1:0] err_q, err_d;
    logic                   slip_d;
    logic                   up_q, down_q, valid_q, slip_q;

    logic [GW-1:0]          good_q, good_d;
    logic [BW-1:0]          bad_q, bad_d;
    logic                   locked_q, locked_d;
    logic                   slip_seen_q, slip_seen_d;
    logic [ERR_W-1:0]       mag;
    logic                   good_cmp;

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            ref_sync_q <= '0;
            fb_sync_q  <= '0;
            ref_prev_q <= 1'b0;
            fb_prev_q  <= 1'b0;
        end else begin
            ref_sync_q <= {ref_sync_q[SYNC_STAGES-2:0], refclk};
            fb_sync_q  <= {fb_sync_q[SYNC_STAGES-2:0], fbclk};
            ref_prev_q <= ref_sync_q[SYNC_STAGES-1];
            fb_prev_q  <= fb_sync_q[SYNC_STAGES-1];
        end
    end

    assign ref_rise = ref_sync_q[SYNC_STAGES-1] & ~ref_prev_q;
    assign fb_rise  = fb_sync_q[SYNC_STAGES-1] & ~fb_prev_q;
    // Pending bits are only ever set in RESET and cleared in IDLE.
    assign ref_ev   = ref_rise | ref_pend_q;
    assign fb_ev    = fb_rise | fb_pend_q;
    assign cnt_inc  = (cnt_q == CMAX) ? cnt_q : cnt_q + CW'(1);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dly_d      = dly_q;
        ref_pend_d = ref_pend_q;
        fb_pend_d  = fb_pend_q;
        load       = 1'b0;
        err_d      = err_q;
        slip_d     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                ref_pend_d = 1'b0;
                fb_pend_d  = 1'b0;
                if (ref_ev && fb_ev) begin
                    state_d = S_RESET;
                    dly_d   = '0;
                    load    = 1'b1;
                    err_d   = '0;
                end else if (ref_ev) begin
                    state_d = S_UP;
                    cnt_d   = CW'(1);
                end else if (fb_ev) begin
                    state_d = S_DN;
                    cnt_d   = CW'(1);
                end
            end
            S_UP: begin
                if (fb_rise) begin
                    state_d = S_RESET;
                    dly_d   = '0;
                    load    = 1'b1;
                    err_d   = $signed({1'b0, cnt_q});
                end else begin
                    cnt_d  = cnt_inc;
                    slip_d = ref_rise;
                end
            end
            S_DN: begin
                if (ref_rise) begin
                    state_d = S_RESET;
                    dly_d   = '0;
                    load    = 1'b1;
                    err_d   = -$signed({1'b0, cnt_q});
                end else begin
                    cnt_d  = cnt_inc;
                    slip_d = fb_rise;
                end
            end
            S_RESET: begin
                if (ref_rise) ref_pend_d = 1'b1;
                if (fb_rise)  fb_pend_d  = 1'b1;
                if (dly_q == DW'(RST_DLY - 1)) begin
                    state_d = S_IDLE;
                    dly_d   = '0;
                end else begin
                    dly_d = dly_q + DW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            dly_q      <= '0;
            ref_pend_q <= 1'b0;
            fb_pend_q  <= 1'b0;
            err_q      <= '0;
            up_q       <= 1'b0;
            down_q     <= 1'b0;
            valid_q    <= 1'b0;
            slip_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dly_q      <= dly_d;
            ref_pend_q <= ref_pend_d;
            fb_pend_q  <= fb_pend_d;
            err_q      <= err_d;
            up_q       <= (state_d == S_UP) || (state_d == S_RESET);
            down_q     <= (state_d == S_DN) || (state_d == S_RESET);
            valid_q    <= load;
            slip_q     <= slip_d;
        end
    end

    // Error magnitude never reaches -2^(ERR_W-1), so negation is safe.
    assign mag      = err_q[ERR_W-1] ? -err_q : err_q;
    assign good_cmp = (mag <= ERR_W'(LOCK_TOL)) && !(slip_seen_q || slip_q);

    always_comb begin
        good_d      = good_q;
        bad_d       = bad_q;
        locked_d    = locked_q;
        slip_seen_d = slip_seen_q | slip_q;
        if (valid_q) begin
            slip_seen_d = 1'b0;
            if (good_cmp) begin
                bad_d = '0;
                if (good_q != GW'(LOCK_CNT)) good_d = good_q + GW'(1);
                if (good_d == GW'(LOCK_CNT)) locked_d = 1'b1;
            end else begin
                good_d = '0;
                if (locked_q) begin
                    if (bad_q + BW'(1) == BW'(UNLOCK_CNT)) begin
                        locked_d = 1'b0;
                        bad_d    = '0;
                    end else begin
                        bad_d = bad_q + BW'(1);
                    end
                end
            end
        end
        if (slip_q) good_d = '0;
    end

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            good_q      <= '0;
            bad_q       <= '0;
            locked_q    <= 1'b0;
            slip_seen_q <= 1'b0;
        end else begin
            good_q      <= good_d;
            bad_q       <= bad_d;
            locked_q    <= locked_d;
            slip_seen_q <= slip_seen_d;
        end
    end

    assign up        = up_q;
    assign down      = down_q;
    assign phase_err = err_q;
    assign err_valid = valid_q;
    assign slip      = slip_q;
    assign locked    = locked_q;

endmodule

// File: tb/tb_dms_pfd_lockdet.sv
// Scoreboard bench for dms_pfd_lockdet: an ERR_W=8 and an ERR_W=4
// instance share the same ref/fb stimulus.
module tb_dms_pfd_lockdet;

    logic ck = 1'b0;
    logic rst_n = 1'b0;
    logic refclk = 1'b0;
    logic fbclk = 1'b0;

    logic              up8, dn8, ev8, sl8, lk8;
    logic signed [7:0] pe8;
    logic              up4, dn4, ev4, sl4, lk4;
    logic signed [3:0] pe4;

    int errors = 0;
    int checks = 0;
    int q8[$];
    int q4[$];
    int valid_cnt, slip_cnt, up_only, dn_only, both;
    int lock_at, unlock_at;
    logic prev_lock;

    always #5 ck = ~ck;

    dms_pfd_lockdet #(
        .SYNC_STAGES(2), .ERR_W(8), .RST_DLY(2),
        .LOCK_TOL(2), .LOCK_CNT(16), .UNLOCK_CNT(4)
    ) dut8 (
        .ck(ck), .rst_n(rst_n), .refclk(refclk), .fbclk(fbclk),
        .up(up8), .down(dn8), .phase_err(pe8), .err_valid(ev8),
        .slip(sl8), .locked(lk8)
    );

    dms_pfd_lockdet #(
        .SYNC_STAGES(2), .ERR_W(4), .RST_DLY(2),
        .LOCK_TOL(2), .LOCK_CNT(16), .UNLOCK_CNT(4)
    ) dut4 (
        .ck(ck), .rst_n(rst_n), .refclk(refclk), .fbclk(fbclk),
        .up(up4), .down(dn4), .phase_err(pe4), .err_valid(ev4),
        .slip(sl4), .locked(lk4)
    );

    function automatic int sat4(input int v);
        if (v > 7) return 7;
        if (v < -7) return -7;
        return v;
    endfunction

    task automatic push(input int v, input int n);
        for (int k = 0; k < n; k++) begin
            q8.push_back(v);
            q4.push_back(sat4(v));
        end
    endtask

    task automatic clear_stats();
        valid_cnt = 0;
        slip_cnt  = 0;
        up_only   = 0;
        dn_only   = 0;
        both      = 0;
        lock_at   = -1;
        unlock_at = -1;
    endtask

    task automatic step(input logic r, input logic f);
        int e;
        @(negedge ck);
        refclk = r;
        fbclk  = f;
        @(posedge ck);
        #1;
        if (ev8) begin
            valid_cnt++;
            checks++;
            if (q8.size() == 0) begin
                errors++;
                $display("FAIL err8_unexpected got=%0d want=none", pe8);
            end else begin
                e = q8.pop_front();
                if (int'(pe8) !== e) begin
                    errors++;
                    $display("FAIL phase_err8 got=%0d want=%0d", pe8, e);
                end
            end
        end
        if (ev4) begin
            checks++;
            if (q4.size() == 0) begin
                errors++;
                $display("FAIL err4_unexpected got=%0d want=none", pe4);
            end else begin
                e = q4.pop_front();
                if (int'(pe4) !== e) begin
                    errors++;
                    $display("FAIL phase_err4 got=%0d want=%0d", pe4, e);
                end
            end
        end
        if (sl8) slip_cnt++;
        if (up8 && !dn8) up_only++;
        if (dn8 && !up8) dn_only++;
        if (up8 && dn8) both++;
        if (lk8 && !prev_lock && lock_at < 0) lock_at = valid_cnt;
        if (!lk8 && prev_lock && unlock_at < 0) unlock_at = valid_cnt;
        prev_lock = lk8;
    endtask

    task automatic drive(input int n, input int pr, input int orf,
                         input int pf, input int off);
        logic r, f;
        for (int i = 0; i < n; i++) begin
            r = (i >= orf) && (((i - orf) % pr) < pr / 2);
            f = (i >= off) && (((i - off) % pf) < pf / 2);
            step(r, f);
        end
    endtask

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic drain(input string name);
        chk({name, "_left8"}, q8.size(), 0);
        chk({name, "_left4"}, q4.size(), 0);
        q8.delete();
        q4.delete();
    endtask

    task automatic reset_dut();
        @(negedge ck);
        rst_n  = 1'b0;
        refclk = 1'b0;
        fbclk  = 1'b0;
        repeat (3) @(negedge ck);
        rst_n = 1'b1;
        q8.delete();
        q4.delete();
        clear_stats();
        prev_lock = 1'b0;
    endtask

    task automatic test_reset();
        @(posedge ck);
        #1;
        chk("rst_up", int'(up8), 0);
        chk("rst_down", int'(dn8), 0);
        chk("rst_valid", int'(ev8), 0);
        chk("rst_slip", int'(sl8), 0);
        chk("rst_locked", int'(lk8), 0);
        chk("rst_err", int'(pe8), 0);
    endtask

    task automatic test_ref_lead();
        reset_dut();
        push(5, 6);
        drive(240, 40, 0, 40, 5);
        chk("lead_up_only", up_only, 30);
        chk("lead_both", both, 12);
        chk("lead_dn_only", dn_only, 0);
        chk("lead_locked", lock_at, -1);
        chk("lead_slip", slip_cnt, 0);
        drain("lead");
    endtask

    task automatic test_lock();
        reset_dut();
        push(0, 20);
        drive(800, 40, 0, 40, 0);
        chk("lock_at", lock_at, 16);
        chk("lock_both", both, 40);
        chk("lock_up_only", up_only, 0);
        chk("lock_dn_only", dn_only, 0);
        drain("lock");
    endtask

    task automatic test_unlock();
        int v0;
        v0        = valid_cnt;
        unlock_at = -1;
        dn_only   = 0;
        both      = 0;
        push(-6, 6);
        drive(240, 40, 6, 40, 0);
        chk("unlock_after", unlock_at - v0, 4);
        chk("unlock_dn_only", dn_only, 36);
        chk("unlock_both", both, 12);
        drain("unlock");
    endtask

    task automatic test_slip();
        reset_dut();
        push(10, 1);
        push(50, 3);
        drive(320, 40, 0, 80, 10);
        chk("slip_count", slip_cnt, 3);
        chk("slip_locked", lock_at, -1);
        drain("slip");
    endtask

    task automatic test_saturation();
        reset_dut();
        push(20, 3);
        drive(180, 60, 0, 60, 20);
        push(-20, 3);
        drive(180, 60, 20, 60, 0);
        drain("sat");
    endtask

    task automatic test_edge_in_reset();
        logic r, f;
        reset_dut();
        push(3, 1);
        push(4, 1);
        for (int i = 0; i < 30; i++) begin
            r = (i inside {0, 1, 4, 5});
            f = (i inside {3, 4, 10, 11});
            step(r, f);
        end
        drain("pend");
    endtask

    task automatic test_reset_mid_up();
        reset_dut();
        repeat (8) step(1'b1, 1'b0);
        chk("mid_up_before", int'({up8, dn8}), 2);
        #2;
        rst_n  = 1'b0;
        refclk = 1'b0;
        #1;
        chk("mid_up_up", int'(up8), 0);
        chk("mid_up_down", int'(dn8), 0);
        chk("mid_up_valid", int'(ev8), 0);
        chk("mid_up_err", int'(pe8), 0);
        @(negedge ck);
        rst_n = 1'b1;
        repeat (4) step(1'b0, 1'b0);
        repeat (10) step(1'b0, 1'b1);
        chk("mid_up_dn_after", int'({up8, dn8}), 1);
        chk("mid_up_nvalid", valid_cnt, 0);
        drain("mid_up");
    endtask

    initial begin
        clear_stats();
        prev_lock = 1'b0;
        test_reset();
        test_ref_lead();
        test_lock();
        test_unlock();
        test_slip();
        test_saturation();
        test_edge_in_reset();
        test_reset_mid_up();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
